// File: rtl/sn76489_psg.sv
// SN76489-style programmable sound generator.
// Three square-wave tone channels and one LFSR noise channel are mixed
// through a 16-step attenuation table into a registered 10-bit output.
module sn76489_psg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [9:0] audio_out
);

    logic [2:0][9:0] tone_q;
    logic [3:0][3:0] att_q;
    logic [2:0]      noiseCtl_q;
    logic [1:0]      latchCh_q;
    logic            latchType_q;
    logic [3:0]      prescale_q;
    logic [2:0][9:0] toneCnt_q;
    logic [2:0]      toneOut_q;
    logic [9:0]      noiseCnt_q;
    logic            noiseFf_q;
    logic [14:0]     lfsr_q;
    logic [9:0]      audio_q;

    logic            tick;
    logic            noiseCtlWr;
    logic [9:0]      noisePeriod;
    logic            lfsrFb;
    logic [2:0]      toneBit;
    logic [9:0]      audio_d;

    // Attenuation step to linear amplitude; step 15 is silence.
    function automatic logic [7:0] volLut(input logic [3:0] a);
        logic [7:0] v;
        case (a)
            4'd0:    v = 8'd255;
            4'd1:    v = 8'd203;
            4'd2:    v = 8'd161;
            4'd3:    v = 8'd128;
            4'd4:    v = 8'd102;
            4'd5:    v = 8'd81;
            4'd6:    v = 8'd64;
            4'd7:    v = 8'd51;
            4'd8:    v = 8'd40;
            4'd9:    v = 8'd32;
            4'd10:   v = 8'd26;
            4'd11:   v = 8'd20;
            4'd12:   v = 8'd16;
            4'd13:   v = 8'd13;
            4'd14:   v = 8'd10;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // Tick generation, noise-control write detect, noise period select and the mix sum.
    always_comb begin
        tick       = ce && (prescale_q == 4'hF);
        noiseCtlWr = wr && (din[7] ? ((din[6:5] == 2'd3) && !din[4])
                                   : ((latchCh_q == 2'd3) && !latchType_q));
        case (noiseCtl_q[1:0])
            2'd0:    noisePeriod = 10'd16;
            2'd1:    noisePeriod = 10'd32;
            2'd2:    noisePeriod = 10'd64;
            default: noisePeriod = tone_q[2];
        endcase
        lfsrFb  = noiseCtl_q[2] ? (lfsr_q[0] ^ lfsr_q[1]) : lfsr_q[0];
        toneBit = '0;
        audio_d = '0;
        for (int n = 0; n < 3; n++) begin
            toneBit[n] = toneOut_q[n] | (tone_q[n] <= 10'd1);
            if (toneBit[n]) begin
                audio_d = audio_d + {2'b00, volLut(att_q[n])};
            end
        end
        if (lfsr_q[0]) begin
            audio_d = audio_d + {2'b00, volLut(att_q[3])};
        end
    end

    // CPU register file: latch bytes select a register, data bytes fill tone high bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_q      <= '0;
            att_q       <= {4{4'hF}};
            noiseCtl_q  <= '0;
            latchCh_q   <= '0;
            latchType_q <= 1'b0;
        end else if (wr) begin
            if (din[7]) begin
                latchCh_q   <= din[6:5];
                latchType_q <= din[4];
                if (din[4]) begin
                    att_q[din[6:5]] <= din[3:0];
                end else if (din[6:5] == 2'd3) begin
                    noiseCtl_q <= din[2:0];
                end else begin
                    for (int n = 0; n < 3; n++) begin
                        if (din[6:5] == 2'(n)) tone_q[n][3:0] <= din[3:0];
                    end
                end
            end else begin
                if (latchType_q) begin
                    att_q[latchCh_q] <= din[3:0];
                end else if (latchCh_q == 2'd3) begin
                    noiseCtl_q <= din[2:0];
                end else begin
                    for (int n = 0; n < 3; n++) begin
                        if (latchCh_q == 2'(n)) tone_q[n][9:4] <= din[5:0];
                    end
                end
            end
        end
    end

    // Prescaler and tone counters; a period of 0 or 1 parks the output high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
            toneCnt_q  <= '0;
            toneOut_q  <= '1;
        end else begin
            if (ce) prescale_q <= prescale_q + 4'd1;
            if (tick) begin
                for (int n = 0; n < 3; n++) begin
                    if (toneCnt_q[n] <= 10'd1) begin
                        toneCnt_q[n] <= tone_q[n];
                        toneOut_q[n] <= (tone_q[n] <= 10'd1) ? 1'b1 : ~toneOut_q[n];
                    end else begin
                        toneCnt_q[n] <= toneCnt_q[n] - 10'd1;
                    end
                end
            end
        end
    end

    // Noise divider and LFSR; a noise-control write restarts both, winning over a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            noiseCnt_q <= '0;
            noiseFf_q  <= 1'b0;
            lfsr_q     <= 15'h4000;
        end else begin
            if (tick) begin
                if (noiseCnt_q <= 10'd1) begin
                    noiseCnt_q <= noisePeriod;
                    noiseFf_q  <= ~noiseFf_q;
                    if (!noiseFf_q) lfsr_q <= {lfsrFb, lfsr_q[14:1]};
                end else begin
                    noiseCnt_q <= noiseCnt_q - 10'd1;
                end
            end
            if (noiseCtlWr) begin
                noiseCnt_q <= '0;
                lfsr_q     <= 15'h4000;
            end
        end
    end

    // Output register: one clk behind any register or channel-bit change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) audio_q <= '0;
        else          audio_q <= audio_d;
    end

    assign audio_out = audio_q;

endmodule

// File: tb/tb_sn76489_psg.sv
// Testbench for sn76489_psg: directed scenarios plus randomized writes,
// all compared against an integer-level model of the chip.
module tb_sn76489_psg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [9:0] audio_out;

    int checks = 0;
    int fails = 0;

    int lut[16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};

    int mTone[3];
    int mAtt[4];
    int mCnt[4];
    int mOut[4];
    int mCtl, mLatchCh, mLatchType, mPre, mLfsr, mAudio;

    sn76489_psg dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .wr(wr),
        .din(din),
        .audio_out(audio_out)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int n = 0; n < 3; n++) begin
            mTone[n] = 0;
            mOut[n]  = 1;
        end
        for (int n = 0; n < 4; n++) begin
            mAtt[n] = 15;
            mCnt[n] = 0;
        end
        mOut[3] = 0;
        mCtl = 0; mLatchCh = 0; mLatchType = 0; mPre = 0;
        mLfsr = 'h4000;
        mAudio = 0;
    endtask

    function automatic int noisePeriodOf();
        case (mCtl % 4)
            0: return 16;
            1: return 32;
            2: return 64;
            default: return mTone[2];
        endcase
    endfunction

    task automatic modelNoiseCtl(input int v);
        mCtl  = v;
        mLfsr = 'h4000;
        mCnt[3] = 0;
    endtask

    // One rising edge of the chip as seen from its register-level behaviour
    task automatic modelEdge(input bit ceV, input bit wrV, input logic [7:0] d);
        int mix, per, fb;
        bit tick;
        mix = 0;
        for (int n = 0; n < 3; n++)
            if (mTone[n] < 2 || mOut[n] == 1) mix += lut[mAtt[n]];
        if (mLfsr % 2 == 1) mix += lut[mAtt[3]];
        tick = ceV && (mPre == 15);
        if (ceV) mPre = (mPre + 1) % 16;
        if (tick) begin
            for (int n = 0; n < 4; n++) begin
                per = (n < 3) ? mTone[n] : noisePeriodOf();
                if (mCnt[n] <= 1) begin
                    mCnt[n] = per;
                    if (n < 3) begin
                        mOut[n] = (per < 2) ? 1 : 1 - mOut[n];
                    end else begin
                        mOut[3] = 1 - mOut[3];
                        if (mOut[3] == 1) begin
                            fb = (mCtl >= 4) ? ((mLfsr ^ (mLfsr >> 1)) & 1) : (mLfsr & 1);
                            mLfsr = (mLfsr >> 1) | (fb << 14);
                        end
                    end
                end else begin
                    mCnt[n] = mCnt[n] - 1;
                end
            end
        end
        if (wrV) begin
            if (d[7]) begin
                mLatchCh = int'(d[6:5]);
                mLatchType = int'(d[4]);
                if (mLatchType == 1) mAtt[mLatchCh] = int'(d[3:0]);
                else if (mLatchCh < 3) mTone[mLatchCh] = (mTone[mLatchCh] & 'h3F0) | int'(d[3:0]);
                else modelNoiseCtl(int'(d[2:0]));
            end else begin
                if (mLatchType == 1) mAtt[mLatchCh] = int'(d[3:0]);
                else if (mLatchCh < 3) mTone[mLatchCh] = (mTone[mLatchCh] & 'hF) | (int'(d[5:0]) << 4);
                else modelNoiseCtl(int'(d[2:0]));
            end
        end
        mAudio = mix;
    endtask

    task automatic cycle(input bit ceV, input bit wrV, input logic [7:0] d);
        ce = ceV;
        wr = wrV;
        din = d;
        @(posedge clk);
        modelEdge(ceV, wrV, d);
        #1;
    endtask

    task automatic doReset();
        wr = 1'b0; ce = 1'b0; din = 8'h00;
        reset_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        wr = 1'b0; ce = 1'b0; din = 8'h00;
        reset_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if (audio_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_audio actual=%0d expected=0", audio_out);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 8'h00);
            checks++;
            if (audio_out !== 10'd0) begin
                fails++;
                $display("[TB] FAIL idle_silent cycle=%0d actual=%0d expected=0", i, audio_out);
            end
        end
    endtask

    task automatic test_att0_dc();
        doReset();
        cycle(1'b0, 1'b1, 8'h90);
        checks++;
        if (audio_out !== 10'd0) begin
            fails++;
            $display("[TB] FAIL dc_one_clk actual=%0d expected=0", audio_out);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (audio_out !== 10'd255) begin
            fails++;
            $display("[TB] FAIL dc_two_clk actual=%0d expected=255", audio_out);
        end
    endtask

    task automatic test_tone_period();
        logic [9:0] last;
        int run, nTrans, bad;
        doReset();
        cycle(1'b0, 1'b1, 8'h90);
        cycle(1'b0, 1'b1, 8'h8E);
        cycle(1'b0, 1'b1, 8'h01);
        last = audio_out;
        run = 0; nTrans = 0; bad = 0;
        for (int i = 0; i < 2500 && nTrans < 4; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (audio_out !== 10'(mAudio)) bad++;
            if (audio_out !== last) begin
                if (nTrans > 0) begin
                    checks++;
                    if (run != 480) begin
                        fails++;
                        $display("[TB] FAIL tone_half_period actual=%0d expected=480", run);
                    end
                end
                nTrans++;
                run = 0;
                last = audio_out;
            end
            run++;
        end
        checks++;
        if (nTrans < 4) begin
            fails++;
            $display("[TB] FAIL tone_timeout transitions=%0d expected=4", nTrans);
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL tone_model_cycles actual=%0d expected=0", bad);
        end
        cycle(1'b1, 1'b1, 8'h9F);
        cycle(1'b1, 1'b0, 8'h00);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (audio_out !== 10'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL mute_ch0 nonzero_cycles=%0d expected=0", bad);
        end
    endtask

    task automatic test_noise_white();
        int bad, riseAt;
        doReset();
        cycle(1'b0, 1'b1, 8'hE4);
        cycle(1'b0, 1'b1, 8'hF0);
        cycle(1'b0, 1'b0, 8'h00);
        bad = 0;
        riseAt = 0;
        for (int j = 1; j <= 8000 && riseAt == 0; j++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (audio_out !== 10'(mAudio)) bad++;
            if (j <= 8 * 512 && audio_out !== 10'd0) bad++;
            if (audio_out == 10'd255) riseAt = j;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL noise_first_bits bad_cycles=%0d expected=0", bad);
        end
        checks++;
        if (riseAt != 6673) begin
            fails++;
            $display("[TB] FAIL noise_shift_timing actual=%0d expected=6673", riseAt);
        end
        cycle(1'b0, 1'b1, 8'h90);
        cycle(1'b0, 1'b1, 8'hB0);
        cycle(1'b0, 1'b1, 8'hD0);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (audio_out !== 10'd1020) begin
            fails++;
            $display("[TB] FAIL full_mix actual=%0d expected=1020", audio_out);
        end
        cycle(1'b0, 1'b1, 8'h9F);
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (audio_out !== 10'd765) begin
            fails++;
            $display("[TB] FAIL mix_ch0_muted actual=%0d expected=765", audio_out);
        end
    endtask

    task automatic test_tick_write();
        logic [9:0] last;
        int run, nTrans, bad;
        bit found;
        doReset();
        cycle(1'b0, 1'b1, 8'h80);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 8'h90);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (mPre == 15 && mCnt[0] <= 1) found = 1'b1;
            else cycle(1'b1, 1'b0, 8'h00);
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL tick_align_timeout actual=0 expected=1");
        end
        cycle(1'b1, 1'b1, 8'h84);
        last = audio_out;
        run = 0; nTrans = 0; bad = 0;
        for (int i = 0; i < 1500 && nTrans < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (audio_out !== 10'(mAudio)) bad++;
            if (audio_out !== last) begin
                if (nTrans == 1) begin
                    checks++;
                    if (run != 256) begin
                        fails++;
                        $display("[TB] FAIL reload_old_period actual=%0d expected=256", run);
                    end
                end
                if (nTrans == 2) begin
                    checks++;
                    if (run != 320) begin
                        fails++;
                        $display("[TB] FAIL reload_new_period actual=%0d expected=320", run);
                    end
                end
                nTrans++;
                run = 0;
                last = audio_out;
            end
            run++;
        end
        checks++;
        if (nTrans < 3 || bad != 0) begin
            fails++;
            $display("[TB] FAIL tick_write_track transitions=%0d bad=%0d expected=3/0", nTrans, bad);
        end
    endtask

    task automatic test_back_to_back();
        int burst;
        logic [7:0] d;
        bit w;
        doReset();
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                ce = 1'b1; wr = 1'b1; din = 8'h90;
                #2;
                reset_n = 1'b0;
                modelReset();
                #1;
                checks++;
                if (audio_out !== 10'd0) begin
                    fails++;
                    $display("[TB] FAIL async_reset_mid_write actual=%0d expected=0", audio_out);
                end
                @(posedge clk);
                #1;
                checks++;
                if (audio_out !== 10'd0) begin
                    fails++;
                    $display("[TB] FAIL reset_held actual=%0d expected=0", audio_out);
                end
                wr = 1'b0;
                reset_n = 1'b1;
            end
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 6);
            w = (burst > 0);
            if (burst > 0) burst--;
            d = 8'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 1)), w, d);
            checks++;
            if (audio_out !== 10'(mAudio)) begin
                fails++;
                $display("[TB] FAIL random_mix cycle=%0d actual=%0d expected=%0d", i, audio_out, mAudio);
            end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_att0_dc();
        test_tone_period();
        test_noise_white();
        test_tick_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
